seq_mul_div: RTL and testbench
==============================

# seq_mul_div

Iterative, parametrised unsigned multiply/divide unit: the sequential successor of the combinational controlled-add/subtract array cells. A single row of WIDTH controlled adder/subtractor cells is reused over WIDTH clock cycles. MUL_BAR selects shift-add multiplication or non-restoring division, as in the array cells. It sits beside the array datapath as the area-optimised option, with a START/BUSY/DONE handshake toward the issuing controller.

## Interface
- WIDTH, 8, operand width N; legal range 2..32; product 2N bits, dividend 2N bits.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- MUL_BAR  in  1  0 = multiply, 1 = divide; latched on accepted START.
- X_IN  in  N  multiplicand (multiply) / divisor (divide); latched on START.
- Y_HI  in  N  dividend high half (divide only; ignored for multiply); latched on START.
- Y_LO  in  N  multiplier (multiply) / dividend low half (divide); latched on START.
- BUSY  out  1  high from the cycle after an accepted START until DONE is asserted.
- DONE  out  1  single-cycle pulse; results are valid from this cycle onward.
- P_HI  out  N  product high half / remainder.
- P_LO  out  N  product low half / quotient.
- OVF  out  1  divide: quotient does not fit in N bits (Y_HI >= X_IN, X_IN != 0).
- DZ  out  1  divide: X_IN == 0.

## Operation
- States: IDLE, CALC, FIX, FIN.
- IDLE:
  - START=1 latches the operands and mode.
  - Multiply, or divide with no exception: go to CALC and load the iteration counter with N.
  - Divide with DZ or OVF: go directly to FIN.
- CALC (multiply): each cycle, if the multiplier LSB is 1, add X to the accumulator high half (N+1-bit sum). Then shift {carry, acc, multiplier} right by 1. After N iterations go to FIN.
- CALC (divide, non-restoring): partial remainder R is N+1 bits, two's complement, initialised to Y_HI.
  - Each cycle: if R >= 0, R = 2R + next dividend bit - X; otherwise R = 2R + next dividend bit + X.
  - Dividend bits are taken MSB first from Y_LO.
  - Quotient bit = NOT sign(R), shifted into Q from the LSB.
  - After N iterations go to FIX.
- FIX (divide only, one cycle): if R < 0, R = R + X. Go to FIN.
- FIN (one cycle):
  - Multiply: P_HI/P_LO = product.
  - Divide: P_HI = R[N-1:0], P_LO = Q.
  - DZ exception: P_HI = Y_HI, P_LO = all ones.
  - OVF exception: P_HI = Y_HI, P_LO = all ones.
  - DONE=1, then go to IDLE.
- Output registers:
  - P_HI, P_LO, OVF and DZ update only in FIN and hold until the next FIN.
  - OVF and DZ are 0 for a multiply.
  - DZ takes priority over OVF; only DZ is set when X_IN=0.
- Handshake:
  - START while BUSY=1, or during FIN, is ignored and not queued.
  - START may be asserted in the cycle right after DONE.
- Arithmetic is unsigned. The exact result must equal floor({Y_HI,Y_LO}/X_IN) and its remainder when no exception is flagged.

## Timing
- Reset (asynchronous, any state): state = IDLE; BUSY=0, DONE=0, P_HI=0, P_LO=0, OVF=0, DZ=0. Counter and working registers are cleared.
- Reset mid-operation aborts the operation with no DONE. The first START after RST deasserts is accepted normally.
- START sampled at edge k (IDLE):
  - BUSY=1 from after edge k.
  - Multiply: DONE=1 in the cycle after edge k+N+1.
  - Divide: DONE=1 in the cycle after edge k+N+2.
  - Divide exception: DONE=1 in the cycle after edge k+1.
- BUSY falls together with DONE rising; BUSY and DONE are never both 1.
- Throughput for back-to-back multiplies: one result per N+2 cycles.

## Test plan
- WIDTH=8, multiply X=13, Y_LO=11 -> P_HI=0x00, P_LO=0x8F, DONE exactly 9 cycles after the START edge, BUSY high for those cycles.
- WIDTH=8, multiply 0xFF x 0xFF -> P_HI=0xFE, P_LO=0x01. Then multiply 0 x 0xA5 -> 0x0000, OVF=DZ=0.
- WIDTH=8, divide {0x00,0x64}/7 -> P_LO=14, P_HI=2, DONE at cycle 10. Then divide {0x07,0xFF}/0x08 -> P_LO=0xFF, P_HI=0x07.
- WIDTH=8, divide {0x10,0x00}/0x08 -> OVF=1, DZ=0, P_HI=0x10, P_LO=0xFF, DONE 1 cycle after START. Divide by X=0 -> DZ=1, OVF=0.
- START pulsed again at cycle 3 of a busy multiply with different operands -> ignored; the first result is unchanged and there is exactly one DONE.
- RST asserted at cycle 4 of a divide -> all outputs 0 immediately, no DONE. A new multiply issued after RST deasserts completes correctly.
- Randomised sweep at WIDTH=4, 8 and 16 against a reference model for both modes, including exception flags.

Source files
------------

// File: rtl/seq_mul_div.sv
// Iterative unsigned multiply/divide unit. One row of WIDTH add/subtract cells
// is reused for WIDTH cycles: shift-add multiply, or non-restoring divide.
//
// state | meaning
// IDLE  | waiting for start; operands and mode latched on an accepted start
// CALC  | one add/subtract + shift per cycle, WIDTH iterations
// FIX   | divide only: final remainder correction when it ended negative
// FIN   | outputs and flags registered, done pulse issued next cycle
module seq_mul_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mul_bar,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_hi,
  input  logic [WIDTH-1:0] y_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p_hi,
  output logic [WIDTH-1:0] p_lo,
  output logic             ovf,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, FIN} state_t;

  state_t           state;
  logic             mode_div;
  logic             exc_dz;
  logic             exc_ovf;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] mq;       // multiplier shifting out / dividend out, quotient in
  logic [WIDTH:0]   r;        // accumulator (multiply) or signed partial remainder
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   x_ext;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_new;
  logic             in_dz;
  logic             in_ovf;

  always_comb begin
    x_ext   = {1'b0, x_q};
    mul_sum = {1'b0, r[WIDTH-1:0]} + (mq[0] ? x_ext : '0);
    div_sh  = {r[WIDTH-1:0], mq[WIDTH-1]};
    // Remainder stays within [-X, X), so wrapping modulo 2^(WIDTH+1) is harmless.
    div_new = r[WIDTH] ? (div_sh + x_ext) : (div_sh - x_ext);
    in_dz   = (x_in == '0);
    in_ovf  = !in_dz && (y_hi >= x_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_div <= 1'b0;
      exc_dz   <= 1'b0;
      exc_ovf  <= 1'b0;
      x_q      <= '0;
      mq       <= '0;
      r        <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      p_hi     <= '0;
      p_lo     <= '0;
      ovf      <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_div <= mul_bar;
            x_q      <= x_in;
            mq       <= y_lo;
            cnt      <= CW'(WIDTH);
            busy     <= 1'b1;
            if (mul_bar) begin
              r       <= {1'b0, y_hi};
              exc_dz  <= in_dz;
              exc_ovf <= in_ovf;
              state   <= (in_dz || in_ovf) ? FIN : CALC;
            end else begin
              r       <= '0;
              exc_dz  <= 1'b0;
              exc_ovf <= 1'b0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (mode_div) begin
            r  <= div_new;
            mq <= {mq[WIDTH-2:0], ~div_new[WIDTH]};
          end else begin
            r  <= {1'b0, mul_sum[WIDTH:1]};
            mq <= {mul_sum[0], mq[WIDTH-1:1]};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= mode_div ? FIX : FIN;
        end
        FIX: begin
          if (r[WIDTH]) r <= r + x_ext;
          state <= FIN;
        end
        FIN: begin
          // r holds product high half, remainder, or the untouched y_hi on exceptions
          p_hi  <= r[WIDTH-1:0];
          p_lo  <= (exc_dz || exc_ovf) ? '1 : mq;
          dz    <= exc_dz;
          ovf   <= exc_ovf;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div.sv
// Scoreboard bench for seq_mul_div: drivers push expected results and latency,
// an independent monitor pops and compares on every done pulse.
module tb_seq_mul_div;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         mul_bar = 1'b0;
  logic [W-1:0] x_in = '0;
  logic [W-1:0] y_hi = '0;
  logic [W-1:0] y_lo = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] p_hi;
  logic [W-1:0] p_lo;
  logic         ovf;
  logic         dz;

  seq_mul_div #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mul_bar(mul_bar),
    .x_in(x_in), .y_hi(y_hi), .y_lo(y_lo),
    .busy(busy), .done(done), .p_hi(p_hi), .p_lo(p_lo), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    logic         dz;
    int           at;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   n_done = 0;
  int   issued = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: independent of the drivers
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      n_done++;
      chk("busy_low_at_done", busy, 0);
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        chk("p_hi", p_hi, e.hi);
        chk("p_lo", p_lo, e.lo);
        chk("ovf", ovf, e.ovf);
        chk("dz", dz, e.dz);
        chk("done_cycle", cyc, e.at);
      end
    end
  end

  // Issue one operation; poke>0 re-pulses start with other operands that many cycles in.
  task automatic issue(input logic mb, input logic [W-1:0] x, input logic [W-1:0] yh,
                       input logic [W-1:0] yl, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic eovf, input logic edz, input int poke);
    exp_t e;
    int   lat;
    int   bc;
    bit   got;
    lat = !mb ? W + 1 : ((edz || eovf) ? 1 : W + 2);
    @(negedge clk);
    mul_bar = mb; x_in = x; y_hi = yh; y_lo = yl; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = '{hi: ehi, lo: elo, ovf: eovf, dz: edz, at: cyc + lat};
    sbq.push_back(e);
    issued++;
    bc = 0;
    got = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      if (busy) bc++;
      start = (poke != 0 && i == poke);
      if (start) begin
        mul_bar = 1'b0; x_in = ~x; y_hi = ~yh; y_lo = ~yl;
      end
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done (t=%0t)", $time);
    end else begin
      chk("busy_length", bc, lat);
    end
  endtask

  task automatic issue_model(input logic mb, input logic [W-1:0] x, input logic [W-1:0] yh,
                             input logic [W-1:0] yl);
    logic [2*W-1:0] prod, dvd, q, rm;
    logic [W-1:0]   ehi, elo;
    logic           eovf, edz;
    eovf = 0; edz = 0;
    if (!mb) begin
      prod = {{W{1'b0}}, x} * {{W{1'b0}}, yl};
      ehi = prod[2*W-1:W]; elo = prod[W-1:0];
    end else if (x == 0) begin
      edz = 1; ehi = yh; elo = '1;
    end else if (yh >= x) begin
      eovf = 1; ehi = yh; elo = '1;
    end else begin
      dvd = {yh, yl};
      q = dvd / {{W{1'b0}}, x};
      rm = dvd % {{W{1'b0}}, x};
      ehi = rm[W-1:0]; elo = q[W-1:0];
    end
    issue(mb, x, yh, yl, ehi, elo, eovf, edz, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_p_hi", p_hi, 0);
    chk("rst_p_lo", p_lo, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dz", dz, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    //     mb    x      yh     yl     hi     lo     ovf dz poke
    issue(1'b0, 8'd13, 8'h00, 8'd11, 8'h00, 8'h8F, 0,  0, 0);
    issue(1'b0, 8'hFF, 8'h00, 8'hFF, 8'hFE, 8'h01, 0,  0, 0);

    // Reset during the 4th cycle of a divide: outputs clear at once, no done
    @(negedge clk);
    mul_bar = 1'b1; x_in = 8'd7; y_hi = 8'h00; y_lo = 8'd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_p_hi", p_hi, 0);
    chk("abort_p_lo", p_lo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 8'h00, 8'h33, 8'hA5, 8'h00, 8'h00, 0,  0, 0);
    issue(1'b1, 8'd7,  8'h00, 8'h64, 8'd2,  8'd14, 0,  0, 0);
    issue(1'b1, 8'h08, 8'h07, 8'hFF, 8'h07, 8'hFF, 0,  0, 0);
    issue(1'b1, 8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFF, 0,  0, 0);
    issue(1'b1, 8'h08, 8'h10, 8'h00, 8'h10, 8'hFF, 1,  0, 0);
    issue(1'b1, 8'h05, 8'h05, 8'h00, 8'h05, 8'hFF, 1,  0, 0);
    issue(1'b1, 8'h00, 8'h12, 8'h34, 8'h12, 8'hFF, 0,  1, 0);
    issue(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 0,  1, 0);
    // Second start during a busy multiply must be dropped
    issue(1'b0, 8'd13, 8'h00, 8'd11, 8'h00, 8'h8F, 0,  0, 3);
    issue(1'b0, 8'd6,  8'h00, 8'd7,  8'h00, 8'd42, 0,  0, 0);

    for (int n = 0; n < 24; n++) begin
      logic         mb;
      logic [W-1:0] x, yh, yl;
      mb = 1'($urandom_range(0, 1));
      x  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      yl = W'($urandom);
      yh = (x != 0 && $urandom_range(0, 3) != 0) ? W'($urandom % x) : W'($urandom);
      issue_model(mb, x, yh, yl);
    end

    repeat (20) @(negedge clk);
    chk("queue_empty", sbq.size(), 0);
    chk("done_count", n_done, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
